dff_bank_rr_arbiter: RTL

//   Shares one WIDTH-bit bank of D flip-flops among N_REQ requesters. Arbitration is round-robin.

---
 rtl/dff_bank_rr_arbiter_pkg.sv | 22 ++
 rtl/dff_bank_rr_arbiter_rr_pick.sv | 28 ++
 rtl/dff_bank_rr_arbiter.sv | 83 ++++++++
 3 files changed

// File: rtl/dff_bank_rr_arbiter_pkg.sv
// dff_arb_pkg: op codes, FSM state encoding and width helper shared by the arbiter files
package dff_arb_pkg;
    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_CLEAR = 2'b01;
    localparam logic [1:0] OP_SET   = 2'b10;
    localparam logic [1:0] OP_HOLD  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    // Never returns 0 so a single-requester pointer still gets one bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n)
            r = r + 1;
        return (r < 1) ? 1 : r;
    endfunction
endpackage

// File: rtl/dff_bank_rr_arbiter_rr_pick.sv
// rr_pick: round-robin winner search starting at ptr, via rotate / find-first / un-rotate
module rr_pick
    import dff_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int PW    = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [PW-1:0]    winner,
    output logic             any_req
);
    logic [N_REQ-1:0] rot;
    int               first;

    always_comb begin
        rot = '0;
        for (int i = 0; i < N_REQ; i++)
            rot[i] = req[(i + int'(ptr)) % N_REQ];
        first = 0;
        for (int i = N_REQ - 1; i >= 0; i--)
            if (rot[i])
                first = i;
        winner = PW'((first + int'(ptr)) % N_REQ);
    end

    assign any_req = |req;
endmodule

// File: rtl/dff_bank_rr_arbiter.sv
// dff_bank_rr_arbiter: round-robin shared register bank, one LOAD/CLEAR/SET/HOLD per req/gnt/ack transaction
module dff_bank_rr_arbiter
    import dff_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [2*N_REQ-1:0]     op,
    input  logic [WIDTH*N_REQ-1:0] wr_data,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       ack,
    output logic                   busy,
    output logic [WIDTH-1:0]       q
);
    localparam int PW = clog2(N_REQ);

    state_t           state;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    win;
    logic [PW-1:0]    pick;
    logic             any_req;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [WIDTH-1:0] q_next;

    rr_pick #(.N_REQ(N_REQ), .PW(PW)) u_pick (
        .req    (req),
        .ptr    (ptr),
        .winner (pick),
        .any_req(any_req)
    );

    always_comb
        q_next = (cmd_op == OP_LOAD)  ? cmd_data :
                 (cmd_op == OP_CLEAR) ? '0 :
                 (cmd_op == OP_SET)   ? '1 : q;

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            ptr      <= '0;
            win      <= '0;
            cmd_op   <= OP_HOLD;
            cmd_data <= '0;
            gnt      <= '0;
            ack      <= '0;
            q        <= '0;
        end else begin
            case (state)
                S_IDLE:
                    if (any_req) begin
                        win      <= pick;
                        gnt      <= N_REQ'(1) << pick;
                        cmd_op   <= op[2*pick +: 2];
                        cmd_data <= wr_data[WIDTH*pick +: WIDTH];
                        state    <= S_GRANT;
                    end
                S_GRANT: begin
                    gnt <= '0;
                    // A withdrawn request aborts without moving the pointer.
                    if (req[win]) begin
                        q     <= q_next;
                        ack   <= N_REQ'(1) << win;
                        ptr   <= (win == PW'(N_REQ - 1)) ? '0 : PW'(win + 1'b1);
                        state <= S_RELEASE;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RELEASE: begin
                    ack   <= '0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
